final2_soc_nios2_qsys_0_jtag_mon_bridge: RTL and testbench

FINAL2_SOC_NIOS2_QSYS_0_JTAG_MON_BRIDGE -- requirements
Module: final2_soc_nios2_qsys_0_jtag_mon_bridge

---
 rtl/final2_soc_nios2_qsys_0_jtag_mon_bridge.sv | 174 +++++++++++++++++
 tb/tb_final2_soc_nios2_qsys_0_jtag_mon_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/final2_soc_nios2_qsys_0_jtag_mon_bridge.sv
// ---------------------------------------------------------------------------
// final2_soc_nios2_qsys_0_jtag_mon_bridge
//
// Bridges JTAG debug-monitor commands (already synchronised into the system
// clock domain) onto a simple word-addressed debug-RAM port with a
// waitrequest stall. A small IDLE/READ/WRITE FSM runs one transfer at a time.
// After each completed transfer the word address auto-increments, so repeated
// commands stream through memory.
//
// Ports
//   clk                      system clock, rising edge
//   reset_n                  asynchronous active-low reset
//   jdo[37:0]                JTAG debug data word
//   take_action_ocimem_a     address load; optional error clear and read
//   take_action_ocimem_b     write command; data taken from jdo[34:3]
//   take_no_action_ocimem_a  read command at the current address
//   MonDReg[31:0]            monitor data register (read result / write data)
//   monitor_ready            high while idle and able to accept a command
//   monitor_error            sticky error (dropped/overrun command, timeout)
//   mem_addr[7:0]            debug-RAM word address
//   mem_wdata[31:0]          write data (mirrors MonDReg)
//   mem_rd, mem_wr           registered read / write strobes
//   mem_rdata[31:0]          read data
//   mem_waitrequest          stalls the current transfer while high
//
// Build option
//   OCIMEM_TIMEOUT_EN  when defined, a transfer stalled for TIMEOUT_CYCLES
//                      consecutive cycles aborts with monitor_error set.
//                      Without it a transfer waits indefinitely.
// ---------------------------------------------------------------------------
module final2_soc_nios2_qsys_0_jtag_mon_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_waitrequest
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Count value on the stall edge that triggers the abort.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  mon_areg, areg_nxt;
  logic [31:0] dreg_nxt;
  logic        err_set, err_clr, err_nxt;

`ifdef OCIMEM_TIMEOUT_EN
  logic [7:0]  tmo_cnt, tmo_nxt;
`endif

  // jdo[37:36] and jdo[2:0] carry no information for this block.
`ifdef OCIMEM_TIMEOUT_EN
  logic unused_bits;
  assign unused_bits = ^{jdo[37:36], jdo[2:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{jdo[37:36], jdo[2:0], TMO_LAST};
`endif

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    areg_nxt  = mon_areg;
    dreg_nxt  = MonDReg;
    err_set   = 1'b0;
    err_clr   = 1'b0;
`ifdef OCIMEM_TIMEOUT_EN
    tmo_nxt   = tmo_cnt;
`endif

    unique case (state)
      IDLE: begin
`ifdef OCIMEM_TIMEOUT_EN
        tmo_nxt = 8'd0;
`endif
        // Fixed priority a > b > n; any lower-priority command on the same
        // edge is dropped and flagged.
        if (take_action_ocimem_a) begin
          areg_nxt = jdo[33:26];
          err_clr  = jdo[35];
          err_set  = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[34]) state_nxt = READ;
        end else if (take_action_ocimem_b) begin
          dreg_nxt  = jdo[34:3];
          err_set   = take_no_action_ocimem_a;
          state_nxt = WRITE;
        end else if (take_no_action_ocimem_a) begin
          state_nxt = READ;
        end
      end

      READ, WRITE: begin
        // Commands during a transfer are overruns: flagged, otherwise ignored.
        err_set = take_action_ocimem_a | take_action_ocimem_b |
                  take_no_action_ocimem_a;
        if (!mem_waitrequest) begin
          if (state == READ) dreg_nxt = mem_rdata;
          areg_nxt  = mon_areg + 8'd1;   // wraps 8'hFF -> 8'h00
          state_nxt = IDLE;
`ifdef OCIMEM_TIMEOUT_EN
          tmo_nxt   = 8'd0;
`endif
        end
`ifdef OCIMEM_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          // Abort: no address increment, no data capture.
          err_set   = 1'b1;
          state_nxt = IDLE;
          tmo_nxt   = 8'd0;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
`endif
      end

      default: state_nxt = IDLE;
    endcase

    // Set dominates a simultaneous clear.
    err_nxt = err_set | (monitor_error & ~err_clr);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_areg      <= 8'd0;
      MonDReg       <= 32'd0;
      monitor_error <= 1'b0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
    end else begin
      state         <= state_nxt;
      mon_areg      <= areg_nxt;
      MonDReg       <= dreg_nxt;
      monitor_error <= err_nxt;
      // Strobes come straight from flops so they are glitch-free.
      mem_rd        <= (state_nxt == READ);
      mem_wr        <= (state_nxt == WRITE);
    end
  end

`ifdef OCIMEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt <= 8'd0;
    else          tmo_cnt <= tmo_nxt;
  end
`endif

  assign monitor_ready = (state == IDLE);
  assign mem_addr      = mon_areg;
  assign mem_wdata     = MonDReg;

endmodule

// File: tb/tb_final2_soc_nios2_qsys_0_jtag_mon_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for final2_soc_nios2_qsys_0_jtag_mon_bridge.
// Directed stimulus pushes the expected outcome of every memory transfer into
// a scoreboard queue; an independent monitor watches the strobes and pops an
// entry each time monitor_ready returns high. Register side effects that do
// not produce a transfer are checked directly by the stimulus process.
// Honours OCIMEM_TIMEOUT_EN (runs the DUT with TIMEOUT_CYCLES = 4 when set).
// ---------------------------------------------------------------------------
module tb_final2_soc_nios2_qsys_0_jtag_mon_bridge;

`ifdef OCIMEM_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        cmd_a, cmd_b, cmd_n;
  logic [31:0] mon_dreg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;

  final2_soc_nios2_qsys_0_jtag_mon_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (cmd_a),
    .take_action_ocimem_b    (cmd_b),
    .take_no_action_ocimem_a (cmd_n),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_rd                  (mem_rd),
    .mem_wr                  (mem_wr),
    .mem_rdata               (mem_rdata),
    .mem_waitrequest         (mem_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    int          cycles;      // strobe-high cycles
    logic [7:0]  addr;        // mem_addr while strobing
    logic [31:0] dreg;        // MonDReg afterwards (and mem_wdata for writes)
    logic [7:0]  addr_after;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] addr,
                                       input logic clr, input logic rd);
    logic [37:0] j;
    j        = '0;
    j[35]    = clr;
    j[34]    = rd;
    j[33:26] = addr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j       = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Presents a one-cycle command; returns 1 ns after the sampling edge.
  task automatic issue(input logic a, input logic b, input logic n,
                       input logic [37:0] j);
    jdo = j; cmd_a = a; cmd_b = b; cmd_n = n;
    @(posedge clk);
    #1;
    cmd_a = 1'b0; cmd_b = 1'b0; cmd_n = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!monitor_ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, monitor_ready}, 32'd1);
  endtask

  task automatic push(input logic w, input int c, input logic [7:0] a,
                      input logic [31:0] d, input logic [7:0] aa,
                      input logic e);
    exp_t x;
    x.is_wr = w; x.cycles = c; x.addr = a; x.dreg = d;
    x.addr_after = aa; x.err = e;
    sb.push_back(x);
  endtask

  // Monitor: records each transfer and compares on its completion.
  initial begin
    logic        prev_ready = 1'b1;
    int          cyc        = 0;
    logic        s_wr       = 1'b0;
    logic [7:0]  s_addr     = '0;
    logic [31:0] s_wd       = '0;
    logic        wd_ok      = 1'b1;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_ready = 1'b1; cyc = 0; wd_ok = 1'b1;
      end else begin
        if (mem_rd || mem_wr) begin
          if (cyc == 0) begin
            s_wr = mem_wr; s_addr = mem_addr; s_wd = mem_wdata;
          end else if (mem_wdata !== s_wd || mem_addr !== s_addr) begin
            wd_ok = 1'b0;
          end
          cyc++;
        end
        if (!prev_ready && monitor_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_transfer", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("xfer_kind",       {31'd0, s_wr},          {31'd0, e.is_wr});
            check("xfer_cycles",     32'(cyc),               32'(e.cycles));
            check("xfer_addr",       {24'd0, s_addr},        {24'd0, e.addr});
            check("xfer_stable",     {31'd0, wd_ok},         32'd1);
            if (e.is_wr) check("xfer_wdata", s_wd, e.dreg);
            check("xfer_mondreg",    mon_dreg,               e.dreg);
            check("xfer_addr_after", {24'd0, mem_addr},      {24'd0, e.addr_after});
            check("xfer_error",      {31'd0, monitor_error}, {31'd0, e.err});
          end
          cyc = 0; wd_ok = 1'b1;
        end
        prev_ready = monitor_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; jdo = '0; cmd_a = 1'b0; cmd_b = 1'b0; cmd_n = 1'b0;
    mem_rdata = '0; mem_waitrequest = 1'b0;
    #12;
    check("rst_ready", {31'd0, monitor_ready}, 32'd1);
    check("rst_rd",    {31'd0, mem_rd},        32'd0);
    check("rst_wr",    {31'd0, mem_wr},        32'd0);
    check("rst_error", {31'd0, monitor_error}, 32'd0);
    check("rst_addr",  {24'd0, mem_addr},      32'd0);
    check("rst_dreg",  mon_dreg,               32'd0);
    check("rst_wdata", mem_wdata,              32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Read at 8'h10, zero wait.
    mem_rdata = 32'hDEAD_BEEF;
    push(1'b0, 1, 8'h10, 32'hDEAD_BEEF, 8'h11, 1'b0);
    issue(1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b0, 1'b1));
    @(negedge clk);
    check("rd_strobe_n1", {30'd0, mem_rd, monitor_ready}, 32'b10);
    @(negedge clk);
    check("rd_ready_n2",  {30'd0, mem_rd, monitor_ready}, 32'b01);

    // Write with 3 wait cycles at 8'h11.
    mem_waitrequest = 1'b1;
    push(1'b1, 4, 8'h11, 32'h1234_5678, 8'h12, 1'b0);
    issue(1'b0, 1'b1, 1'b0, mk_b(32'h1234_5678));
    repeat (3) @(posedge clk);
    #1 mem_waitrequest = 1'b0;
    wait_idle(10, "wr_wait_done");

    // Overrun during a stalled write, then error clear.
    mem_waitrequest = 1'b1;
    push(1'b1, 2, 8'h12, 32'hA5A5_0F0F, 8'h13, 1'b1);
    issue(1'b0, 1'b1, 1'b0, mk_b(32'hA5A5_0F0F));
    issue(1'b0, 1'b0, 1'b1, 38'd0);
    mem_waitrequest = 1'b0;
    wait_idle(10, "ovr_done");
    issue(1'b1, 1'b0, 1'b0, mk_a(8'h40, 1'b1, 1'b0));
    @(negedge clk);
    check("clr_error", {31'd0, monitor_error}, 32'd0);
    check("clr_addr",  {24'd0, mem_addr},      32'h40);

    // a + b together: a wins, b dropped, no transfer.
    issue(1'b1, 1'b1, 1'b0, mk_a(8'h20, 1'b0, 1'b0));
    @(negedge clk);
    check("pri_ab_addr",  {24'd0, mem_addr},      32'h20);
    check("pri_ab_dreg",  mon_dreg,               32'hA5A5_0F0F);
    check("pri_ab_error", {31'd0, monitor_error}, 32'd1);
    check("pri_ab_ready", {31'd0, monitor_ready}, 32'd1);

    // b + n together after clearing: write runs, n dropped.
    issue(1'b1, 1'b0, 1'b0, mk_a(8'h20, 1'b1, 1'b0));
    push(1'b1, 1, 8'h20, 32'hCAFE_F00D, 8'h21, 1'b1);
    issue(1'b0, 1'b1, 1'b1, mk_b(32'hCAFE_F00D));
    wait_idle(10, "pri_bn_done");

    // Clear and set on the same edge: set wins.
    issue(1'b1, 1'b0, 1'b0, mk_a(8'h30, 1'b1, 1'b0));
    @(negedge clk);
    check("pre_setclr_error", {31'd0, monitor_error}, 32'd0);
    issue(1'b1, 1'b0, 1'b1, mk_a(8'h30, 1'b1, 1'b0));
    @(negedge clk);
    check("setclr_error", {31'd0, monitor_error}, 32'd1);
    check("setclr_ready", {31'd0, monitor_ready}, 32'd1);

    // Wrap: load 8'hFF (clearing the error) and read.
    mem_rdata = 32'h0BAD_F00D;
    push(1'b0, 1, 8'hFF, 32'h0BAD_F00D, 8'h00, 1'b0);
    issue(1'b1, 1'b0, 1'b0, mk_a(8'hFF, 1'b1, 1'b1));
    wait_idle(10, "wrap_done");

    // Reset pulsed during a stalled read (with an overrun to set the error).
    mem_waitrequest = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    issue(1'b0, 1'b0, 1'b1, 38'd0);
    issue(1'b0, 1'b0, 1'b1, 38'd0);
    @(negedge clk);
    check("pre_rst_error", {31'd0, monitor_error}, 32'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, monitor_ready}, 32'd1);
    check("arst_rd",    {31'd0, mem_rd},        32'd0);
    check("arst_wr",    {31'd0, mem_wr},        32'd0);
    check("arst_error", {31'd0, monitor_error}, 32'd0);
    check("arst_addr",  {24'd0, mem_addr},      32'd0);
    check("arst_dreg",  mon_dreg,               32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    // First command right after release is sampled on the next edge.
    mem_waitrequest = 1'b0;
    mem_rdata = 32'h1111_2222;
    push(1'b0, 1, 8'h05, 32'h1111_2222, 8'h06, 1'b0);
    issue(1'b1, 1'b0, 1'b0, mk_a(8'h05, 1'b0, 1'b1));
    wait_idle(10, "post_rst_done");

    // Stuck waitrequest.
    mem_waitrequest = 1'b1;
`ifdef OCIMEM_TIMEOUT_EN
    push(1'b0, 4, 8'h06, 32'h1111_2222, 8'h06, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 38'd0);
    wait_idle(20, "tmo_done");
    mem_waitrequest = 1'b0;
`else
    issue(1'b0, 1'b0, 1'b1, 38'd0);
    repeat (1000) @(negedge clk);
    check("stall_rd",    {31'd0, mem_rd},        32'd1);
    check("stall_ready", {31'd0, monitor_ready}, 32'd0);
    check("stall_addr",  {24'd0, mem_addr},      32'h06);
    check("stall_dreg",  mon_dreg,               32'h1111_2222);
    @(posedge clk);
    #3 reset_n = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    mem_waitrequest = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
